// File: rtl/reg_share_arb.sv
// rtl/reg_share_arb.sv - round-robin write arbiter for one shared data register
// Optional locked-ownership mode is built when REG_SHARE_ARB_LOCK_EN is defined.
module reg_share_arb #(
  parameter int unsigned       NUM_REQ  = 4,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [DATA_W-1:0] RST_VAL  = '0,
  parameter int unsigned       MAX_LOCK = 8,
  localparam int unsigned      IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
`ifdef REG_SHARE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock_i,
`endif
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [DATA_W-1:0]         q_o,
  output logic                      valid_o,
  output logic [IDX_W-1:0]          owner_o
);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("reg_share_arb: NUM_REQ out of range");
  end
  if (MAX_LOCK < 1 || MAX_LOCK > 255) begin : g_bad_max_lock
    $error("reg_share_arb: MAX_LOCK out of range");
  end

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [DATA_W-1:0]  q_q, q_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] k);
    return (k == IDX_W'(NUM_REQ - 1)) ? '0 : k + 1'b1;
  endfunction

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[IDX_W'((int'(ptr_q) + i) % NUM_REQ)]) begin
        found = 1'b1;
        win   = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

`ifdef REG_SHARE_ARB_LOCK_EN
  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    gnt_d   = '0;
    q_d     = q_q;
    valid_d = valid_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_idx  = win;
`ifdef REG_SHARE_ARB_LOCK_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB: begin
        wr_en = found;
        if (found) begin
          ptr_d = next_ptr(win);
          // With MAX_LOCK=1 the entering write already exhausts the lock.
          if (lock_i[win] && MAX_LOCK > 1) begin
            state_d = LOCK;
            cnt_d   = 8'd1;
          end
        end
      end
      LOCK: begin
        wr_idx = owner_q;
        wr_en  = req_i[owner_q];
        if (wr_en) cnt_d = cnt_q + 8'd1;
        if (!lock_i[owner_q] || (wr_en && (cnt_q + 8'd1 == 8'(MAX_LOCK)))) begin
          state_d = ARB;
          ptr_d   = next_ptr(owner_q);
        end
      end
      default: state_d = ARB;
    endcase
`else
    wr_en = found;
    if (found) ptr_d = next_ptr(win);
`endif
    if (wr_en) begin
      gnt_d   = NUM_REQ'(1) << wr_idx;
      q_d     = data_i[int'(wr_idx)*DATA_W +: DATA_W];
      owner_d = wr_idx;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q   <= '0;
      q_q     <= RST_VAL;
      valid_q <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
`ifdef REG_SHARE_ARB_LOCK_EN
      state_q <= ARB;
      cnt_q   <= 8'd0;
`endif
    end else begin
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
`ifdef REG_SHARE_ARB_LOCK_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt_o   = gnt_q;
  assign q_o     = q_q;
  assign valid_o = valid_q;
  assign owner_o = owner_q;

endmodule

// File: tb/tb_reg_share_arb.sv
// tb/tb_reg_share_arb.sv - directed self-checking bench for reg_share_arb
// Lock scenarios run only when REG_SHARE_ARB_LOCK_EN is defined.
module tb_reg_share_arb;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam logic [DW-1:0] RV = 8'h33;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NR-1:0]  req_i = '0;
  logic [NR*DW-1:0] data_i;
  logic [NR-1:0]  lock_i = '0;
  logic [NR-1:0]  gnt_o;
  logic [DW-1:0]  q_o;
  logic           valid_o;
  logic [1:0]     owner_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_share_arb #(.NUM_REQ(NR), .DATA_W(DW), .RST_VAL(RV), .MAX_LOCK(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_i),
    .data_i  (data_i),
`ifdef REG_SHARE_ARB_LOCK_EN
    .lock_i  (lock_i),
`endif
    .gnt_o   (gnt_o),
    .q_o     (q_o),
    .valid_o (valid_o),
    .owner_o (owner_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [7:0] q,
                           input logic v, input logic [1:0] o);
    check({tag, ".gnt"}, 32'(gnt_o), 32'(g));
    check({tag, ".q"}, 32'(q_o), 32'(q));
    check({tag, ".valid"}, 32'(valid_o), 32'(v));
    check({tag, ".owner"}, 32'(owner_o), 32'(o));
  endtask

  initial begin
    for (int k = 0; k < NR; k++) data_i[k*DW +: DW] = 8'hA0 + 8'(k);

    tick();
    reset = 1'b0;
    check_out("reset", 4'b0000, RV, 1'b0, 2'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out("idle", 4'b0000, RV, 1'b0, 2'd0);
    end

    // Full contention: rotation 0,1,2,3,0,...
    req_i = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      check_out("rr", 4'b0001 << (c % 4), 8'hA0 + 8'(c % 4), 1'b1, 2'(c % 4));
    end

    // Grant to 2 leaves ptr=3, then 0011 must wrap to 0, then 1.
    req_i = 4'b0100; tick();
    check_out("g2", 4'b0100, 8'hA2, 1'b1, 2'd2);
    req_i = 4'b0011; tick();
    check_out("wrap0", 4'b0001, 8'hA0, 1'b1, 2'd0);
    tick();
    check_out("wrap1", 4'b0010, 8'hA1, 1'b1, 2'd1);

    req_i = 4'b0000; tick();
    check_out("hold", 4'b0000, 8'hA1, 1'b1, 2'd1);

    // Sole requester gets back-to-back writes.
    req_i = 4'b0100; tick();
    check_out("sole_a", 4'b0100, 8'hA2, 1'b1, 2'd2);
    tick();
    check_out("sole_b", 4'b0100, 8'hA2, 1'b1, 2'd2);

`ifdef REG_SHARE_ARB_LOCK_EN
    // ptr=3: requester 1 locks, forced release after 3 writes.
    req_i = 4'b0110; lock_i = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out("lock_max", 4'b0010, 8'hA1, 1'b1, 2'd1);
    end
    tick();
    check_out("lock_rel", 4'b0100, 8'hA2, 1'b1, 2'd2);

    // ptr=3: lock by 1, then 1 idles while 0 requests.
    req_i = 4'b0010; lock_i = 4'b0010; tick();
    check_out("lock_in", 4'b0010, 8'hA1, 1'b1, 2'd1);
    req_i = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      tick();
      check_out("lock_idle", 4'b0000, 8'hA1, 1'b1, 2'd1);
    end
    req_i = 4'b0011; lock_i = 4'b0000; tick();
    check_out("lock_last", 4'b0010, 8'hA1, 1'b1, 2'd1);
    tick();
    check_out("lock_after", 4'b0001, 8'hA0, 1'b1, 2'd0);

    // Reset while locked.
    data_i[1*DW +: DW] = 8'h5A;
    req_i = 4'b0010; lock_i = 4'b0010; tick();
    check_out("lock_5a", 4'b0010, 8'h5A, 1'b1, 2'd1);
    reset = 1'b1; tick();
    reset = 1'b0;
    check_out("lock_rst", 4'b0000, RV, 1'b0, 2'd0);
    req_i = 4'b1111; lock_i = 4'b0000; tick();
    check_out("lock_rst_g", 4'b0001, 8'hA0, 1'b1, 2'd0);
    data_i[1*DW +: DW] = 8'hA1;
`endif

    // Mid-operation reset with ptr=2 must restart scanning at 0.
    req_i = 4'b0010; tick();
    check_out("pre_rst", 4'b0010, 8'hA1, 1'b1, 2'd1);
    reset = 1'b1; tick();
    reset = 1'b0;
    check_out("mid_rst", 4'b0000, RV, 1'b0, 2'd0);
    req_i = 4'b1111; tick();
    check_out("post_rst", 4'b0001, 8'hA0, 1'b1, 2'd0);
    tick();
    check_out("post_rst2", 4'b0010, 8'hA1, 1'b1, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
